// File: rtl/cdb_arbiter_if.sv
// Request, flush and CDB broadcast signals of the three-requester CDB arbiter.
// The arbiter uses the slave modport; whoever drives requests uses master.
interface cdb_arbiter_if #(
    parameter int TAG_W  = 4,
    parameter int DATA_W = 32
);
    logic              in_flush;

    logic              in_req0_valid;
    logic [TAG_W-1:0]  in_req0_tag;
    logic [DATA_W-1:0] in_req0_value;
    logic              in_req0_isjump;
    logic [DATA_W-1:0] in_req0_jump_addr;

    logic              in_req1_valid;
    logic [TAG_W-1:0]  in_req1_tag;
    logic [DATA_W-1:0] in_req1_value;
    logic              in_req1_isjump;
    logic [DATA_W-1:0] in_req1_jump_addr;

    logic              in_req2_valid;
    logic [TAG_W-1:0]  in_req2_tag;
    logic [DATA_W-1:0] in_req2_value;
    logic              in_req2_isjump;
    logic [DATA_W-1:0] in_req2_jump_addr;

    logic              out_req0_ready;
    logic              out_req1_ready;
    logic              out_req2_ready;

    logic [TAG_W-1:0]  out_cdb_rob_tag;
    logic [DATA_W-1:0] out_cdb_value;
    logic              out_cdb_isjump;
    logic [DATA_W-1:0] out_cdb_jump_addr;
    logic              out_busy;

    modport master (
        output in_flush,
        output in_req0_valid, in_req0_tag, in_req0_value, in_req0_isjump, in_req0_jump_addr,
        output in_req1_valid, in_req1_tag, in_req1_value, in_req1_isjump, in_req1_jump_addr,
        output in_req2_valid, in_req2_tag, in_req2_value, in_req2_isjump, in_req2_jump_addr,
        input  out_req0_ready, out_req1_ready, out_req2_ready,
        input  out_cdb_rob_tag, out_cdb_value, out_cdb_isjump, out_cdb_jump_addr, out_busy
    );

    modport slave (
        input  in_flush,
        input  in_req0_valid, in_req0_tag, in_req0_value, in_req0_isjump, in_req0_jump_addr,
        input  in_req1_valid, in_req1_tag, in_req1_value, in_req1_isjump, in_req1_jump_addr,
        input  in_req2_valid, in_req2_tag, in_req2_value, in_req2_isjump, in_req2_jump_addr,
        output out_req0_ready, out_req1_ready, out_req2_ready,
        output out_cdb_rob_tag, out_cdb_value, out_cdb_isjump, out_cdb_jump_addr, out_busy
    );
endinterface

// File: rtl/cdb_arbiter.sv
// CDB arbiter: three requesters (two ALUs, one branch unit) each own a
// one-entry hold buffer; occupied buffers are granted round-robin, one per
// cycle, and the winner is broadcast on the registered CDB the next cycle.
// A tag of 0 means "no broadcast", so tag-0 offers are never accepted.
module cdb_arbiter #(
    parameter int TAG_W  = 4,
    parameter int DATA_W = 32
) (
    input  logic         clk,
    input  logic         rst,
    cdb_arbiter_if.slave bus
);
    localparam int N = 3;

    // modulo-3 add for the round-robin pointer (operands always 0..2)
    function automatic logic [1:0] wrap3(input logic [1:0] a, input logic [1:0] b);
        logic [2:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= 3'd3) s = s - 3'd3;
        return s[1:0];
    endfunction

    logic [N-1:0]      req_v, req_j;
    logic [TAG_W-1:0]  req_tag  [N];
    logic [DATA_W-1:0] req_val  [N];
    logic [DATA_W-1:0] req_addr [N];

    logic [N-1:0]      buf_v_q, buf_v_d, buf_j_q, buf_j_d;
    logic [TAG_W-1:0]  buf_tag_q  [N];
    logic [TAG_W-1:0]  buf_tag_d  [N];
    logic [DATA_W-1:0] buf_val_q  [N];
    logic [DATA_W-1:0] buf_val_d  [N];
    logic [DATA_W-1:0] buf_addr_q [N];
    logic [DATA_W-1:0] buf_addr_d [N];
    logic [1:0]        rr_q, rr_d;

    logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
    logic [DATA_W-1:0] cdb_val_q, cdb_val_d;
    logic              cdb_j_q, cdb_j_d;
    logic [DATA_W-1:0] cdb_addr_q, cdb_addr_d;

    logic [N-1:0]      grant, ready, accept;
    logic              gnt_any;
    logic [1:0]        gnt_idx, scan_idx;

    // Gather the per-requester interface signals into indexable arrays.
    always_comb begin
        req_v       = {bus.in_req2_valid, bus.in_req1_valid, bus.in_req0_valid};
        req_j       = {bus.in_req2_isjump, bus.in_req1_isjump, bus.in_req0_isjump};
        req_tag[0]  = bus.in_req0_tag;
        req_tag[1]  = bus.in_req1_tag;
        req_tag[2]  = bus.in_req2_tag;
        req_val[0]  = bus.in_req0_value;
        req_val[1]  = bus.in_req1_value;
        req_val[2]  = bus.in_req2_value;
        req_addr[0] = bus.in_req0_jump_addr;
        req_addr[1] = bus.in_req1_jump_addr;
        req_addr[2] = bus.in_req2_jump_addr;
    end

    // Round-robin grant over occupied buffers, scanning rr, rr+1, rr+2.
    always_comb begin
        grant    = '0;
        gnt_any  = 1'b0;
        gnt_idx  = '0;
        scan_idx = '0;
        for (int i = 0; i < N; i++) begin
            scan_idx = wrap3(rr_q, 2'(i));
            if (!gnt_any && buf_v_q[scan_idx]) begin
                gnt_any           = 1'b1;
                gnt_idx           = scan_idx;
                grant[scan_idx]   = 1'b1;
            end
        end
    end

    // A buffer can take a new offer when empty or being drained this cycle.
    always_comb begin
        ready  = ~buf_v_q | grant;
        accept = '0;
        for (int k = 0; k < N; k++) begin
            accept[k] = req_v[k] && ready[k] && !bus.in_flush && (req_tag[k] != '0);
        end
    end

    // Next state: drain the winner to the CDB, refill accepted buffers; flush wipes all.
    always_comb begin
        buf_v_d    = buf_v_q;
        buf_j_d    = buf_j_q;
        buf_tag_d  = buf_tag_q;
        buf_val_d  = buf_val_q;
        buf_addr_d = buf_addr_q;
        rr_d       = rr_q;
        cdb_tag_d  = '0;
        cdb_val_d  = '0;
        cdb_j_d    = 1'b0;
        cdb_addr_d = '0;

        if (gnt_any) begin
            buf_v_d[gnt_idx] = 1'b0;
            cdb_tag_d        = buf_tag_q[gnt_idx];
            cdb_val_d        = buf_val_q[gnt_idx];
            cdb_j_d          = buf_j_q[gnt_idx];
            cdb_addr_d       = buf_addr_q[gnt_idx];
            rr_d             = wrap3(gnt_idx, 2'd1);
        end

        for (int k = 0; k < N; k++) begin
            if (accept[k]) begin
                buf_v_d[k]    = 1'b1;
                buf_j_d[k]    = req_j[k];
                buf_tag_d[k]  = req_tag[k];
                buf_val_d[k]  = req_val[k];
                buf_addr_d[k] = req_addr[k];
            end
        end

        // the cycle's grant is discarded, not broadcast, and rr does not move
        if (bus.in_flush) begin
            buf_v_d    = '0;
            rr_d       = rr_q;
            cdb_tag_d  = '0;
            cdb_val_d  = '0;
            cdb_j_d    = 1'b0;
            cdb_addr_d = '0;
        end
    end

    // State register; reset takes priority over a simultaneous flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_v_q    <= '0;
            buf_j_q    <= '0;
            rr_q       <= '0;
            cdb_tag_q  <= '0;
            cdb_val_q  <= '0;
            cdb_j_q    <= 1'b0;
            cdb_addr_q <= '0;
            for (int k = 0; k < N; k++) begin
                buf_tag_q[k]  <= '0;
                buf_val_q[k]  <= '0;
                buf_addr_q[k] <= '0;
            end
        end else begin
            buf_v_q    <= buf_v_d;
            buf_j_q    <= buf_j_d;
            buf_tag_q  <= buf_tag_d;
            buf_val_q  <= buf_val_d;
            buf_addr_q <= buf_addr_d;
            rr_q       <= rr_d;
            cdb_tag_q  <= cdb_tag_d;
            cdb_val_q  <= cdb_val_d;
            cdb_j_q    <= cdb_j_d;
            cdb_addr_q <= cdb_addr_d;
        end
    end

    assign bus.out_req0_ready    = ready[0];
    assign bus.out_req1_ready    = ready[1];
    assign bus.out_req2_ready    = ready[2];
    assign bus.out_cdb_rob_tag   = cdb_tag_q;
    assign bus.out_cdb_value     = cdb_val_q;
    assign bus.out_cdb_isjump    = cdb_j_q;
    assign bus.out_cdb_jump_addr = cdb_addr_q;
    assign bus.out_busy          = |buf_v_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: a directed vector table, hand-written multi-cycle
// sequences, and a randomized run, all compared against a slot-level model.
module tb_cdb_arbiter;
    localparam int TAG_W  = 4;
    localparam int DATA_W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cdb_arbiter_if #(.TAG_W(TAG_W), .DATA_W(DATA_W)) bus ();

    cdb_arbiter #(.TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // ---------------- stimulus state ----------------
    bit          d_v    [3];
    logic [3:0]  d_tag  [3];
    logic [31:0] d_val  [3];
    bit          d_j    [3];
    logic [31:0] d_addr [3];
    bit          d_flush;

    task automatic apply();
        bus.in_flush          = d_flush;
        bus.in_req0_valid     = d_v[0];  bus.in_req0_tag = d_tag[0];  bus.in_req0_value = d_val[0];
        bus.in_req0_isjump    = d_j[0];  bus.in_req0_jump_addr = d_addr[0];
        bus.in_req1_valid     = d_v[1];  bus.in_req1_tag = d_tag[1];  bus.in_req1_value = d_val[1];
        bus.in_req1_isjump    = d_j[1];  bus.in_req1_jump_addr = d_addr[1];
        bus.in_req2_valid     = d_v[2];  bus.in_req2_tag = d_tag[2];  bus.in_req2_value = d_val[2];
        bus.in_req2_isjump    = d_j[2];  bus.in_req2_jump_addr = d_addr[2];
    endtask

    task automatic clear_in();
        for (int k = 0; k < 3; k++) begin
            d_v[k] = 0; d_tag[k] = '0; d_val[k] = '0; d_j[k] = 0; d_addr[k] = '0;
        end
        d_flush = 0;
        apply();
    endtask

    function automatic logic get_rdy(int k);
        case (k)
            0:       return bus.out_req0_ready;
            1:       return bus.out_req1_ready;
            default: return bus.out_req2_ready;
        endcase
    endfunction

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [3:0]  tag;
        logic [31:0] val;
        logic        j;
        logic [31:0] addr;
    } ent_t;

    bit   m_full [3];
    ent_t m_ent  [3];
    int   m_rr;
    ent_t m_cdb;

    // first occupied slot in round-robin order, or -1 when all empty
    function automatic int m_pick();
        for (int i = 0; i < 3; i++) begin
            if (m_full[(m_rr + i) % 3]) return (m_rr + i) % 3;
        end
        return -1;
    endfunction

    function automatic void model_edge();
        int g = m_pick();
        bit rdy [3];
        for (int k = 0; k < 3; k++) rdy[k] = !m_full[k] || (g == k);
        if (rst) begin
            for (int k = 0; k < 3; k++) m_full[k] = 0;
            m_rr  = 0;
            m_cdb = '0;
            return;
        end
        if (d_flush) begin
            for (int k = 0; k < 3; k++) m_full[k] = 0;
            m_cdb = '0;
            return;
        end
        if (g >= 0) begin
            m_cdb     = m_ent[g];
            m_full[g] = 0;
            m_rr      = (g + 1) % 3;
        end else begin
            m_cdb = '0;
        end
        for (int k = 0; k < 3; k++) begin
            if (d_v[k] && rdy[k] && d_tag[k] != 0) begin
                m_full[k] = 1;
                m_ent[k]  = '{tag: d_tag[k], val: d_val[k], j: d_j[k], addr: d_addr[k]};
            end
        end
    endfunction

    // ---------------- checking ----------------
    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_model(string ph);
        int g = m_pick();
        for (int k = 0; k < 3; k++)
            chk($sformatf("%s.ready%0d", ph, k), 64'(get_rdy(k)), 64'(!m_full[k] || g == k));
        chk({ph, ".busy"}, 64'(bus.out_busy), 64'(m_full[0] | m_full[1] | m_full[2]));
        chk({ph, ".cdb_tag"},  64'(bus.out_cdb_rob_tag),   64'(m_cdb.tag));
        chk({ph, ".cdb_val"},  64'(bus.out_cdb_value),     64'(m_cdb.val));
        chk({ph, ".cdb_jmp"},  64'(bus.out_cdb_isjump),    64'(m_cdb.j));
        chk({ph, ".cdb_addr"}, 64'(bus.out_cdb_jump_addr), 64'(m_cdb.addr));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          rst, flush;
        bit [2:0]    v;
        bit [3:0]    t0, t1, t2;
        bit [2:0]    jm;
        bit [31:0]   val;
        bit [2:0]    erdy;
        bit          ebusy;
        bit [3:0]    etag;
        bit [31:0]   eval;
        bit          ej;
        bit [31:0]   eaddr;
    } vec_t;

    function automatic vec_t mkrow(bit r, bit f, bit [2:0] v, bit [3:0] t0, bit [3:0] t1,
                                   bit [3:0] t2, bit [2:0] jm, bit [31:0] val, bit [2:0] erdy,
                                   bit ebusy, bit [3:0] etag, bit [31:0] eval, bit ej,
                                   bit [31:0] eaddr);
        vec_t x;
        x.rst = r; x.flush = f; x.v = v; x.t0 = t0; x.t1 = t1; x.t2 = t2; x.jm = jm;
        x.val = val; x.erdy = erdy; x.ebusy = ebusy; x.etag = etag; x.eval = eval;
        x.ej = ej; x.eaddr = eaddr;
        return x;
    endfunction

    vec_t tbl [$];

    initial begin
        int          cnt [3];
        int          bcount [3];
        int          nb;
        int          rr_before;
        logic        rdy_s [3];
        logic [3:0]  t;

        // each row: inputs applied in a cycle, expectations = outputs in that same cycle
        // single offer: tag 3 in cycle 1 -> CDB only in cycle 3
        tbl.push_back(mkrow(0,0,3'b001, 3,0,0, 3'b000, 32'h11, 3'b111,0, 0,0,0,0));
        tbl.push_back(mkrow(0,0,3'b000, 0,0,0, 3'b000, 32'h0,  3'b111,1, 0,0,0,0));
        tbl.push_back(mkrow(0,0,3'b000, 0,0,0, 3'b000, 32'h0,  3'b111,0, 3,32'h11,0,0));
        tbl.push_back(mkrow(0,0,3'b000, 0,0,0, 3'b000, 32'h0,  3'b111,0, 0,0,0,0));
        // reset to bring rr back to 0
        tbl.push_back(mkrow(1,0,3'b000, 0,0,0, 3'b000, 32'h0,  3'b111,0, 0,0,0,0));
        // three-way contention: tags 1,2,4 (req2 jump to 0x100) -> CDB cycles 3,4,5
        tbl.push_back(mkrow(0,0,3'b111, 1,2,4, 3'b100, 32'h20, 3'b111,0, 0,0,0,0));
        tbl.push_back(mkrow(0,0,3'b000, 0,0,0, 3'b000, 32'h0,  3'b001,1, 0,0,0,0));
        tbl.push_back(mkrow(0,0,3'b000, 0,0,0, 3'b000, 32'h0,  3'b011,1, 1,32'h20,0,0));
        tbl.push_back(mkrow(0,0,3'b000, 0,0,0, 3'b000, 32'h0,  3'b111,1, 2,32'h21,0,0));
        tbl.push_back(mkrow(0,0,3'b000, 0,0,0, 3'b000, 32'h0,  3'b111,0, 4,32'h22,1,32'h100));
        tbl.push_back(mkrow(0,0,3'b000, 0,0,0, 3'b000, 32'h0,  3'b111,0, 0,0,0,0));
        // tag-0 offer from req2 is ignored
        tbl.push_back(mkrow(0,0,3'b100, 0,0,0, 3'b000, 32'h55, 3'b111,0, 0,0,0,0));
        tbl.push_back(mkrow(0,0,3'b100, 0,0,0, 3'b000, 32'h55, 3'b111,0, 0,0,0,0));
        tbl.push_back(mkrow(0,0,3'b000, 0,0,0, 3'b000, 32'h0,  3'b111,0, 0,0,0,0));

        // ---- reset ----
        for (int k = 0; k < 3; k++) begin m_full[k] = 0; m_ent[k] = '0; end
        m_rr = 0; m_cdb = '0;
        rst = 1'b1;
        clear_in();
        tick();
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) chk($sformatf("reset.ready%0d", k), 64'(get_rdy(k)), 64'd1);
        chk("reset.busy",     64'(bus.out_busy),          64'd0);
        chk("reset.cdb_tag",  64'(bus.out_cdb_rob_tag),   64'd0);
        chk("reset.cdb_val",  64'(bus.out_cdb_value),     64'd0);
        chk("reset.cdb_jmp",  64'(bus.out_cdb_isjump),    64'd0);
        chk("reset.cdb_addr", 64'(bus.out_cdb_jump_addr), 64'd0);

        // ---- table ----
        foreach (tbl[i]) begin
            rst     = tbl[i].rst;
            d_flush = tbl[i].flush;
            d_tag[0] = tbl[i].t0; d_tag[1] = tbl[i].t1; d_tag[2] = tbl[i].t2;
            for (int k = 0; k < 3; k++) begin
                d_v[k]    = tbl[i].v[k];
                d_val[k]  = tbl[i].val + 32'(k);
                d_j[k]    = tbl[i].jm[k];
                d_addr[k] = tbl[i].jm[k] ? 32'h100 : 32'h0;
            end
            apply();
            for (int k = 0; k < 3; k++)
                chk($sformatf("vec%0d.ready%0d", i, k), 64'(get_rdy(k)), 64'(tbl[i].erdy[k]));
            chk($sformatf("vec%0d.busy", i),     64'(bus.out_busy),          64'(tbl[i].ebusy));
            chk($sformatf("vec%0d.cdb_tag", i),  64'(bus.out_cdb_rob_tag),   64'(tbl[i].etag));
            chk($sformatf("vec%0d.cdb_val", i),  64'(bus.out_cdb_value),     64'(tbl[i].eval));
            chk($sformatf("vec%0d.cdb_jmp", i),  64'(bus.out_cdb_isjump),    64'(tbl[i].ej));
            chk($sformatf("vec%0d.cdb_addr", i), 64'(bus.out_cdb_jump_addr), 64'(tbl[i].eaddr));
            tick();
        end
        rst = 1'b0;
        clear_in();

        // ---- fairness: all three continuously valid, rolling tags per requester ----
        // requester k uses tags 5k+1 .. 5k+5 so the broadcast source is recoverable
        for (int k = 0; k < 3; k++) begin cnt[k] = 0; bcount[k] = 0; end
        nb = 0;
        for (int c = 0; c < 32; c++) begin
            for (int k = 0; k < 3; k++) begin
                d_v[k]   = 1;
                d_tag[k] = 4'(k * 5 + (cnt[k] % 5) + 1);
                d_val[k] = 32'(c * 16 + k);
            end
            apply();
            check_model("fair");
            for (int k = 0; k < 3; k++) rdy_s[k] = get_rdy(k);
            tick();
            for (int k = 0; k < 3; k++) if (rdy_s[k]) cnt[k]++;
            t = bus.out_cdb_rob_tag;
            if (t != 0 && nb < 30) begin
                chk($sformatf("fair.order%0d", nb), 64'((int'(t) - 1) / 5), 64'(nb % 3));
                bcount[(int'(t) - 1) / 5]++;
                nb++;
            end
        end
        chk("fair.total", 64'(nb), 64'd30);
        for (int k = 0; k < 3; k++) chk($sformatf("fair.count%0d", k), 64'(bcount[k]), 64'd10);
        clear_in();
        for (int c = 0; c < 4; c++) begin check_model("drain1"); tick(); end

        // ---- back-to-back on req1: tags 1..8 in consecutive cycles ----
        for (int c = 0; c < 10; c++) begin
            d_v[1]   = (c < 8);
            d_tag[1] = 4'(c + 1);
            d_val[1] = 32'hB00 + 32'(c);
            apply();
            check_model("b2b");
            if (c < 8) chk($sformatf("b2b.ready_c%0d", c), 64'(bus.out_req1_ready), 64'd1);
            tick();
            chk($sformatf("b2b.tag_c%0d", c + 1), 64'(bus.out_cdb_rob_tag),
                64'((c >= 1 && c <= 8) ? c : 0));
        end
        clear_in();
        for (int c = 0; c < 2; c++) begin check_model("drain2"); tick(); end

        // ---- flush with three buffers full (plus a same-cycle offer) ----
        for (int k = 0; k < 3; k++) begin d_v[k] = 1; d_tag[k] = 4'(5 + k); d_val[k] = 32'hF0 + 32'(k); end
        apply();
        check_model("flushA");
        tick();
        rr_before = m_rr;
        clear_in();
        d_v[0] = 1; d_tag[0] = 4'd9; d_flush = 1;
        apply();
        check_model("flushB");
        tick();
        clear_in();
        chk("flush.busy_after", 64'(bus.out_busy), 64'd0);
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("flush.no_bcast%0d", c), 64'(bus.out_cdb_rob_tag), 64'd0);
            check_model("flushC");
            tick();
        end
        // rr held through the flush: the first winner of a new round is rr_before
        for (int k = 0; k < 3; k++) begin d_v[k] = 1; d_tag[k] = 4'(k + 1); end
        apply();
        tick();
        clear_in();
        tick();
        chk("flush.rr_held", 64'(bus.out_cdb_rob_tag), 64'(rr_before + 1));
        for (int c = 0; c < 3; c++) begin check_model("drain3"); tick(); end

        // ---- reset mid-operation: move rr to 1, fill, then reset ----
        d_v[0] = 1; d_tag[0] = 4'd3; apply(); tick();
        clear_in(); tick(); tick();
        for (int k = 0; k < 3; k++) begin d_v[k] = 1; d_tag[k] = 4'(10 + k); end
        apply();
        tick();
        clear_in();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstmid.cdb_tag", 64'(bus.out_cdb_rob_tag), 64'd0);
        chk("rstmid.busy",    64'(bus.out_busy),        64'd0);
        check_model("rstmid");
        for (int k = 0; k < 3; k++) begin d_v[k] = 1; d_tag[k] = 4'(k + 1); end
        apply();
        tick();
        clear_in();
        tick();
        chk("rstmid.rr_zero", 64'(bus.out_cdb_rob_tag), 64'd1);
        for (int c = 0; c < 3; c++) begin check_model("drain4"); tick(); end

        // tag-0 offer from req2 after reset is never accepted or broadcast
        d_v[2] = 1; d_tag[2] = 4'd0; d_val[2] = 32'hDEAD; apply();
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("tag0.busy%0d", c), 64'(bus.out_busy), 64'd0);
            chk($sformatf("tag0.cdb%0d", c),  64'(bus.out_cdb_rob_tag), 64'd0);
            tick();
        end
        clear_in();

        // ---- randomized run against the model ----
        for (int c = 0; c < 800; c++) begin
            for (int k = 0; k < 3; k++) begin
                d_v[k]    = ($urandom_range(0, 3) != 0);
                d_tag[k]  = 4'($urandom_range(0, 15));
                d_val[k]  = $urandom;
                d_j[k]    = 1'($urandom_range(0, 1));
                d_addr[k] = $urandom;
            end
            d_flush = ($urandom_range(0, 31) == 0);
            rst     = ($urandom_range(0, 63) == 0);
            apply();
            check_model("rand");
            tick();
        end
        rst = 1'b0;
        clear_in();
        check_model("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
